// File: rtl/wait_timer_bank.sv
// wait_timer_bank
//   A bank of CHANNELS independent wait timers for the vending controller
//   (coin debounce, dispense hold, refund timeout). Each channel counts
//   ticks while its enable is high. In HOLD mode it raises a level flag once
//   k_wait ticks have elapsed. In REPEAT mode it pulses every k_wait ticks.
//   A low enable clears the channel synchronously. The enable is never used
//   as a reset.
//
// Ports
//   clock       in   1               all state changes on posedge
//   reset       in   1               asynchronous, active-high; clears all state
//   in          in   CHANNELS        per-channel enable; counts while high
//   mode        in   CHANNELS        0 = HOLD, 1 = REPEAT (sampled at start)
//   k_wait      in   CHANNELS*WIDTH  per-channel terminal count, ch i = [i*WIDTH +: WIDTH]
//   waited      out  CHANNELS        HOLD: level flag; REPEAT: same as done_pulse
//   done_pulse  out  CHANNELS        one-cycle pulse at each expiry
//   any_waited  out  1               OR of the registered waited bits
//
// Configuration
//   WAIT_PRESCALE_EN  when defined, a shared free-running prescaler makes a
//                     tick once every PRESCALE clocks, and the timers advance
//                     only on tick edges. When it is not defined, there is a
//                     tick on every clock and PRESCALE is unused.
//
// Channel states
//   state   | meaning
//   S_IDLE  | enable low or not yet started; timer 0, waited 0
//   S_COUNT | counting ticks toward k_eff (REPEAT stays here across reloads)
//   S_DONE  | HOLD expired; timer frozen, waited held high until enable drops

module wait_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] k_wait,
    output logic [CHANNELS-1:0]       waited,
    output logic [CHANNELS-1:0]       done_pulse,
    output logic                      any_waited
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t             state    [CHANNELS];
    logic [WIDTH-1:0]   timer    [CHANNELS];
    logic [WIDTH-1:0]   k_lat    [CHANNELS];
    logic               mode_lat [CHANNELS];
    logic               tick;

    // A terminal count of 0 behaves like 1.
    function automatic logic [WIDTH-1:0] k_eff(input logic [WIDTH-1:0] k);
        return (k == '0) ? WIDTH'(1) : k;
    endfunction

`ifdef WAIT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else if (pre_cnt == PW'(PRESCALE - 1))
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PW'(1);
    end

    assign tick = (pre_cnt == PW'(PRESCALE - 1));
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]    <= S_IDLE;
                timer[i]    <= '0;
                k_lat[i]    <= '0;
                mode_lat[i] <= 1'b0;
            end
            waited     <= '0;
            done_pulse <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!in[i]) begin
                    // A low enable wins over everything, including an expiry on this edge.
                    state[i]      <= S_IDLE;
                    timer[i]      <= '0;
                    waited[i]     <= 1'b0;
                    done_pulse[i] <= 1'b0;
                end else begin
                    case (state[i])
                        S_IDLE: begin
                            waited[i]     <= 1'b0;
                            done_pulse[i] <= 1'b0;
                            if (tick) begin
                                k_lat[i]    <= k_wait[i*WIDTH +: WIDTH];
                                mode_lat[i] <= mode[i];
                                if (k_eff(k_wait[i*WIDTH +: WIDTH]) == WIDTH'(1)) begin
                                    // With k_eff = 1, the channel expires on the start edge.
                                    waited[i]     <= 1'b1;
                                    done_pulse[i] <= 1'b1;
                                    if (mode[i]) begin
                                        state[i] <= S_COUNT;
                                        timer[i] <= '0;
                                    end else begin
                                        state[i] <= S_DONE;
                                        timer[i] <= WIDTH'(1);
                                    end
                                end else begin
                                    state[i] <= S_COUNT;
                                    timer[i] <= WIDTH'(1);
                                end
                            end
                        end
                        S_COUNT: begin
                            waited[i]     <= 1'b0;
                            done_pulse[i] <= 1'b0;
                            if (tick) begin
                                if (timer[i] + WIDTH'(1) == k_eff(k_lat[i])) begin
                                    waited[i]     <= 1'b1;
                                    done_pulse[i] <= 1'b1;
                                    if (mode_lat[i]) begin
                                        // REPEAT reload picks up the current k_wait.
                                        timer[i] <= '0;
                                        k_lat[i] <= k_wait[i*WIDTH +: WIDTH];
                                    end else begin
                                        state[i] <= S_DONE;
                                        timer[i] <= timer[i] + WIDTH'(1);
                                    end
                                end else begin
                                    timer[i] <= timer[i] + WIDTH'(1);
                                end
                            end
                        end
                        S_DONE: begin
                            waited[i]     <= 1'b1;
                            done_pulse[i] <= 1'b0;
                        end
                        default: begin
                            state[i]      <= S_IDLE;
                            timer[i]      <= '0;
                            waited[i]     <= 1'b0;
                            done_pulse[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign any_waited = |waited;

endmodule

// File: tb/tb_wait_timer_bank.sv
module tb_wait_timer_bank;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int PS = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [CH-1:0]   in    = '0;
    logic [CH-1:0]   mode  = '0;
    logic [CH*W-1:0] k_wait = '0;
    logic [CH-1:0]   waited;
    logic [CH-1:0]   done_pulse;
    logic            any_waited;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    wait_timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PS)) dut (
        .clock      (clock),
        .reset      (reset),
        .in         (in),
        .mode       (mode),
        .k_wait     (k_wait),
        .waited     (waited),
        .done_pulse (done_pulse),
        .any_waited (any_waited)
    );

    always #5 clock = ~clock;

    // Reference model: for each channel, count the elapsed ticks since the
    // start or the last reload, and compare that count with the effective
    // terminal count.
    int            m_n   [CH];
    int            m_k   [CH];
    bit            m_run [CH];
    bit            m_rep [CH];
    bit            m_done[CH];
    logic [CH-1:0] exp_w = '0;
    logic [CH-1:0] exp_p = '0;
    int            m_pre = 0;

    function automatic int keff_of(input int ch, input logic [CH*W-1:0] kv);
        int v;
        v = int'(kv[ch*W +: W]);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clock or posedge reset) begin
        bit t;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_n[i] = 0; m_k[i] = 0; m_run[i] = 0; m_rep[i] = 0; m_done[i] = 0;
            end
            exp_w = '0;
            exp_p = '0;
            m_pre = 0;
        end else begin
`ifdef WAIT_PRESCALE_EN
            t = (m_pre == PS - 1);
            m_pre = (m_pre == PS - 1) ? 0 : m_pre + 1;
`else
            t = 1'b1;
`endif
            for (int i = 0; i < CH; i++) begin
                exp_p[i] = 1'b0;
                if (!in[i]) begin
                    m_run[i] = 0; m_done[i] = 0; exp_w[i] = 1'b0;
                end else if (m_done[i]) begin
                    exp_w[i] = 1'b1;
                end else begin
                    exp_w[i] = 1'b0;
                    if (t) begin
                        if (!m_run[i]) begin
                            m_run[i] = 1; m_n[i] = 0;
                            m_k[i]   = keff_of(i, k_wait);
                            m_rep[i] = mode[i];
                        end
                        m_n[i]++;
                        if (m_n[i] == m_k[i]) begin
                            exp_p[i] = 1'b1;
                            exp_w[i] = 1'b1;
                            if (m_rep[i]) begin
                                m_n[i] = 0;
                                m_k[i] = keff_of(i, k_wait);
                            end else begin
                                m_done[i] = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_waited", 32'(waited), 32'(exp_w));
            chk("model_done_pulse", 32'(done_pulse), 32'(exp_p));
            chk("model_any_waited", 32'(any_waited), 32'(|exp_w));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic set_k(input int ch, input int val);
        k_wait[ch*W +: W] = W'(val);
    endtask

    initial begin
        logic [12:1] mask;

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk_en = 1;

`ifndef WAIT_PRESCALE_EN
        // Reset while ch0 is in the middle of a count
        mode[0] = 1'b0; set_k(0, 5); in[0] = 1'b1;
        step(3);
        reset = 1'b1;
        #1;
        chk("rst_waited", 32'(waited), 0);
        chk("rst_pulse", 32'(done_pulse), 0);
        chk("rst_any", 32'(any_waited), 0);
        step(1);
        reset = 1'b0;
        step(4);
        chk("rst_resume_early", 32'(waited[0]), 0);
        step(1);
        chk("rst_resume_w", 32'(waited[0]), 1);
        chk("rst_resume_p", 32'(done_pulse[0]), 1);
        step(1);
        chk("rst_hold_p", 32'(done_pulse[0]), 0);
        chk("rst_hold_w", 32'(waited[0]), 1);
        in[0] = 1'b0;
        step(1);

        // HOLD on ch1 with k = 4
        mode[1] = 1'b0; set_k(1, 4); in[1] = 1'b1;
        step(3);
        chk("hold_e3_w", 32'(waited[1]), 0);
        step(1);
        chk("hold_e4_w", 32'(waited[1]), 1);
        chk("hold_e4_p", 32'(done_pulse[1]), 1);
        step(1);
        chk("hold_e5_p", 32'(done_pulse[1]), 0);
        chk("hold_e5_w", 32'(waited[1]), 1);
        in[1] = 1'b0;
        step(1);
        chk("hold_clear_w", 32'(waited[1]), 0);

        // REPEAT on ch2 with k = 3; the second pass changes k to 2 after edge 4
        for (int v = 0; v < 2; v++) begin
            mask = (v == 0) ? 12'b1001_0010_0100 : 12'b1010_1010_0100;
            mode[2] = 1'b1; set_k(2, 3); in[2] = 1'b1;
            for (int e = 1; e <= 12; e++) begin
                step(1);
                chk("rep_pulse", 32'(done_pulse[2]), 32'(mask[e]));
                chk("rep_waited", 32'(waited[2]), 32'(mask[e]));
                if (v == 1 && e == 4) set_k(2, 2);
            end
            in[2] = 1'b0;
            step(1);
        end

        // Boundaries on ch3: k = 0 and k = 1 both expire on edge 1
        for (int kv = 0; kv < 2; kv++) begin
            mode[3] = 1'b0; set_k(3, kv); in[3] = 1'b1;
            step(1);
            chk("k01_w", 32'(waited[3]), 1);
            in[3] = 1'b0;
            step(1);
        end
        set_k(3, 255); in[3] = 1'b1;
        step(254);
        chk("k255_early", 32'(waited[3]), 0);
        step(1);
        chk("k255_w", 32'(waited[3]), 1);
        chk("k255_p", 32'(done_pulse[3]), 1);
        step(3);
        chk("k255_nowrap", 32'(waited[3]), 1);
        in[3] = 1'b0;
        step(1);

        // REPEAT with k = 1 pulses on every edge
        mode[3] = 1'b1; set_k(3, 1); in[3] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step(1);
            chk("rep_k1_p", 32'(done_pulse[3]), 1);
        end
        in[3] = 1'b0; mode[3] = 1'b0;
        step(1);

        // Enable dropped on the expiry edge
        mode[1] = 1'b0; set_k(1, 3); in[1] = 1'b1;
        step(2);
        in[1] = 1'b0;
        step(1);
        chk("drop_on_exp_p", 32'(done_pulse[1]), 0);
        chk("drop_on_exp_w", 32'(waited[1]), 0);

        // k and mode changes during a count are ignored
        in[1] = 1'b1;
        step(1);
        set_k(1, 10); mode[1] = 1'b1;
        step(1);
        chk("midchg_e2", 32'(waited[1]), 0);
        step(1);
        chk("midchg_e3_p", 32'(done_pulse[1]), 1);
        step(1);
        chk("midchg_hold_w", 32'(waited[1]), 1);
        chk("midchg_hold_p", 32'(done_pulse[1]), 0);
        in[1] = 1'b0; mode[1] = 1'b0;
        step(1);

        // ch0 and ch3 expiring in the same cycle
        set_k(0, 2); set_k(3, 2); mode[0] = 1'b0; mode[3] = 1'b0;
        in[0] = 1'b1; in[3] = 1'b1;
        step(2);
        chk("simul_p", 32'(done_pulse), 32'h9);
        chk("simul_any", 32'(any_waited), 1);
        in[0] = 1'b0;
        step(1);
        chk("simul_clr_w", 32'(waited), 32'h8);
        chk("simul_clr_any", 32'(any_waited), 1);
        in[3] = 1'b0;
        step(1);
`else
        // Prescaled HOLD: k = 3 takes 3 ticks of PS clocks each
        begin
            int rise;
            rise = 0;
            mode[3] = 1'b0; set_k(3, 3); in[3] = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                step(1);
                if (waited[3] && rise == 0) rise = c;
            end
            chk("psc_rise_window", 32'(rise >= 9 && rise <= 12), 1);
            in[3] = 1'b0;
            step(1);
            chk("psc_clear", 32'(waited[3]), 0);
        end
`endif

        step(2);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
